multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter STATE_W, default 4, state register width.
REQ-002 SHALL have port clock, input, 1, sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high.
REQ-004 SHALL have inputs opcode[6:0], funct3[2:0], funct7b5 (1), taken from the instruction register.
REQ-005 SHALL have inputs zero (1), ALU zero flag, and mem_ready (1), memory completion handshake.
REQ-006 SHALL have outputs pc_write, adr_src, mem_write, ir_write, reg_write (1 each), datapath strobes and selects.
REQ-007 SHALL have outputs result_src[1:0], alu_src_a[1:0], alu_src_b[1:0], imm_src[1:0], alu_control[2:0] (datapath selects), illegal (1) and state[STATE_W-1:0] (debug).

Function
REQ-008 SHALL implement a Moore FSM with these encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, JALR=11.
REQ-009 FETCH SHALL drive adr_src=0, alu_src_a=00, alu_src_b=10, ALU add, result_src=10; it SHALL hold until mem_ready=1, and ir_write/pc_write SHALL pulse only in that cycle; FETCH->DECODE.
REQ-010 DECODE SHALL drive alu_src_a=01, alu_src_b=01, ALU add, and SHALL branch on opcode: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1100011->BEQ, 1101111->JAL, 1100111->JALR (macro only), otherwise->FETCH with illegal=1 for that cycle.
REQ-011 MEMADR SHALL drive alu_src_a=10, alu_src_b=01, ALU add; it SHALL go to MEMREAD if opcode[5]=0, else MEMWRITE.
REQ-012 MEMREAD SHALL drive adr_src=1, result_src=00, and SHALL hold until mem_ready=1, then go to MEMWB.
REQ-013 MEMWB SHALL drive result_src=01, reg_write=1, then go to FETCH.
REQ-014 MEMWRITE SHALL drive adr_src=1, result_src=00, and mem_write=1 continuously until the mem_ready=1 cycle, then go to FETCH.
REQ-015 EXECUTER SHALL drive alu_src_a=10, alu_src_b=00, ALU_op=10; EXECUTEI SHALL drive alu_src_a=10, alu_src_b=01, ALU_op=10; both SHALL go to ALUWB.
REQ-016 ALUWB SHALL drive result_src=00, reg_write=1, then go to FETCH.
REQ-017 BEQ SHALL drive alu_src_a=10, alu_src_b=00, ALU_op=01, result_src=00, with pc_write=zero, then go to FETCH.
REQ-018 JAL SHALL drive alu_src_a=01, alu_src_b=10, ALU add, result_src=00, pc_write=1, then go to ALUWB.
REQ-019 alu_control SHALL be decoded from the internal ALU_op plus funct3/funct7b5/opcode[5]: 00->000 add, 01->001 sub, 10->funct decode (sub only for R-type with funct7b5=1).
REQ-020 imm_src SHALL decode combinationally from opcode: I-type/load/jalr=00, store=01, branch=10, jal=11, else 00.
REQ-021 Strobes not listed for a state SHALL be 0; unlisted selects SHALL be 00.
REQ-022 Unreachable state codes SHALL transition to FETCH with all strobes 0.
REQ-023 state SHALL equal the current state register.

Reset
REQ-024 With reset=1 at a rising edge, the state SHALL become FETCH regardless of the current state, including mid-memory-wait.
REQ-025 While reset=1, pc_write, ir_write, mem_write, reg_write and illegal SHALL be forced to 0.

Configuration
REQ-026 With MULTICYCLE_JALR_EN defined, JALR SHALL drive alu_src_a=10, alu_src_b=01, ALU add, then go to JAL; this writes rs1+imm to the PC, then PC+4 to rd.
REQ-027 Without MULTICYCLE_JALR_EN, the JALR state SHALL NOT exist, and opcode 1100111 SHALL take the illegal path.

Structure
REQ-028 State encodings, opcode constants and ALU_op codes SHALL live in the shared CPU defines header.
REQ-029 The FSM SHALL be a sub-module main_fsm; the top SHALL instantiate main_fsm and the existing ALU decoder, and SHALL combine pc_write = (branch & zero) | pc_update.

Verification
REQ-030 add (opcode 0110011, funct3 000, funct7b5=0) with mem_ready=1 -> states 0,1,6,8,0; alu_control=000 in EXECUTER; reg_write=1 only in ALUWB.
REQ-031 lw with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB with reg_write=1, result_src=01.
REQ-032 sw with mem_ready=0 for 2 cycles -> mem_write=1 for 3 consecutive cycles, then FETCH.
REQ-033 beq with zero=1 -> pc_write=1 in BEQ and alu_control=001; with zero=0 -> pc_write=0.
REQ-034 Opcode 1111111 -> illegal=1 for one DECODE cycle, then FETCH; reset asserted in MEMREAD -> FETCH next cycle with strobes 0.
REQ-035 jalr with MULTICYCLE_JALR_EN -> states 1,11,10,8; without the macro -> illegal=1.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared CPU defines: FSM state encodings, opcodes, ALU op and ALU control codes.
// Latency: none (declarations and one combinational helper only).
// Backpressure: n/a. Optional JALR state is guarded by MULTICYCLE_JALR_EN.
package multicycle_controller_pkg;

  // Main FSM state encodings (debug-visible on the state output)
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
`ifdef MULTICYCLE_JALR_EN
    S_JAL      = 4'd10,
    S_JALR     = 4'd11
`else
    S_JAL      = 4'd10
`endif
  } state_e;

  // Major opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Internal ALU op requested by the FSM
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // ALU control codes presented to the datapath
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Immediate format select from the opcode alone
  function automatic logic [1:0] imm_src_decode(input logic [6:0] op);
    logic [1:0] r;
    r = 2'b00;
    case (op)
      OP_STORE:  r = 2'b01;
      OP_BRANCH: r = 2'b10;
      OP_JAL:    r = 2'b11;
      default:   r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_dec.sv
// ALU decoder: maps the FSM's ALU op plus funct fields to an ALU control code.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  alu_op_e    alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o
);

  // Subtract only for R-type with funct7b5; I-type funct7 bits are immediate data
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b100:  alu_control_o = ALU_XOR;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller_main_fsm.sv
// Main Moore FSM of the multicycle controller; JALR state only with MULTICYCLE_JALR_EN.
// Latency: one state per clock; outputs are a function of the current state (plus mem_ready gating).
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready; reset zeroes all strobes.
module main_fsm
  import multicycle_controller_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode_i,
  input  logic       mem_ready_i,
  output state_e     state_o,
  output logic       branch_o,
  output logic       pc_update_o,
  output logic       adr_src_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic       illegal_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output alu_op_e    alu_op_o
);

  state_e state_q, state_d;

  // State register with synchronous reset to FETCH
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and Moore outputs; strobes are squashed while reset is high
  always_comb begin
    state_d      = S_FETCH;
    branch_o     = 1'b0;
    pc_update_o  = 1'b0;
    adr_src_o    = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    illegal_o    = 1'b0;
    result_src_o = 2'b00;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    alu_op_o     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = mem_ready_i;
        pc_update_o  = mem_ready_i;
        state_d      = mem_ready_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        case (opcode_i)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
`ifdef MULTICYCLE_JALR_EN
          OP_JALR:           state_d = S_JALR;
`endif
          default: begin
            state_d   = S_FETCH;
            illegal_o = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_d     = opcode_i[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src_o = 1'b1;
        state_d   = mem_ready_i ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_o   = 1'b1;
        mem_write_o = 1'b1;
        state_d     = mem_ready_i ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op_o    = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_o = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = ALUOP_SUB;
        branch_o    = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_update_o = 1'b1;
        state_d     = S_ALUWB;
      end
`ifdef MULTICYCLE_JALR_EN
      // rs1+imm is computed here; JAL then writes it to the PC and PC+4 goes to rd
      S_JALR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_d     = S_JAL;
      end
`endif
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      branch_o    = 1'b0;
      pc_update_o = 1'b0;
      mem_write_o = 1'b0;
      ir_write_o  = 1'b0;
      reg_write_o = 1'b0;
      illegal_o   = 1'b0;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V controller top: main FSM, ALU decoder, immediate select, PC write combine.
// Latency: Moore outputs follow the state register; imm_src/alu_control are combinational.
// Backpressure: memory waits via mem_ready; MULTICYCLE_JALR_EN adds the JALR path.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         imm_src,
  output logic [2:0]         alu_control,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_e  fsm_state;
  alu_op_e alu_op;
  logic    branch;
  logic    pc_update;

  main_fsm u_main_fsm (
    .clock        (clock),
    .reset        (reset),
    .opcode_i     (opcode),
    .mem_ready_i  (mem_ready),
    .state_o      (fsm_state),
    .branch_o     (branch),
    .pc_update_o  (pc_update),
    .adr_src_o    (adr_src),
    .mem_write_o  (mem_write),
    .ir_write_o   (ir_write),
    .reg_write_o  (reg_write),
    .illegal_o    (illegal),
    .result_src_o (result_src),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op)
  );

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .op5_i         (opcode[5]),
    .alu_control_o (alu_control)
  );

  // Branch strobe is already squashed in reset, so the combine needs no extra gating
  assign pc_write = (branch & zero) | pc_update;
  assign imm_src  = imm_src_decode(opcode);
  assign state    = STATE_W'(fsm_state);

endmodule
